// File: rtl/sync_bus_hs.sv
// sync_bus_hs: multi-bit clock-domain crossing for control/status words, inclk -> outclk.
//
// A whole word is captured in inclk and moved with a two-phase toggle req/ack handshake.
// Only the req and ack toggles cross domains (through synchroniser flops). The captured
// data bus is sampled in outclk only after req has been synchronised, so it is stable
// when read and cannot show bit skew.
//
// Ports:
//   inclk   in   source-domain clock
//   areset  in   reset, synchronous to inclk, active-high (re-synchronised into outclk)
//   outclk  in   destination-domain clock
//   iin     in   [kWidth] source word
//   ipush   in   request transfer of iin; honoured only while irdy=1
//   irdy    out  inclk: handshake idle, a push is accepted
//   iovf    out  inclk: sticky, a push arrived while irdy=0 and was dropped
//   oout    out  [kWidth] outclk: last transferred word, stable between updates
//   ovalid  out  outclk: one-cycle pulse when oout updates
//
// Optional feature, macro SYNC_BUS_CHANGE_PUSH_EN: when defined, a transfer is also
// started automatically whenever irdy=1 and iin differs from the last captured word.
// Auto-pushes never set iovf.

module sync_bus_hs #(
    parameter int unsigned       kWidth   = 8,
    parameter int unsigned       kStages  = 2,
    parameter logic [kWidth-1:0] kResetTo = '0
) (
    input  logic              inclk,
    input  logic              areset,
    input  logic              outclk,
    input  logic [kWidth-1:0] iin,
    input  logic              ipush,
    output logic              irdy,
    output logic              iovf,
    output logic [kWidth-1:0] oout,
    output logic              ovalid
);

    // ---------------------------------------------------------------- inclk domain
    logic [kWidth-1:0] cap_q, cap_d;
    logic              req_q, req_d;
    logic              irdy_q, irdy_d;
    logic              iovf_q, iovf_d;
    (* ASYNC_REG = "TRUE" *) logic [kStages-1:0] ack_sync_q;
    logic [kStages-1:0] ack_sync_d;
    logic               ack_s;
    logic               push_eff;

    // Outclk-domain ack toggle, declared here because the inclk side samples it.
    logic ack_q, ack_d;

    assign ack_s = ack_sync_q[kStages-1];

`ifdef SYNC_BUS_CHANGE_PUSH_EN
    // The capture register holds the last captured word (kResetTo after reset).
    logic auto_push;
    assign auto_push = irdy_q && (iin != cap_q);
    assign push_eff  = ipush | auto_push;
`else
    assign push_eff  = ipush;
`endif

    always_comb begin
        cap_d      = cap_q;
        req_d      = req_q;
        irdy_d     = irdy_q;
        iovf_d     = iovf_q;
        ack_sync_d = {ack_sync_q[kStages-2:0], ack_q};
        if (push_eff && irdy_q) begin
            cap_d  = iin;
            req_d  = ~req_q;
            irdy_d = 1'b0;
        end else if (!irdy_q && (ack_s == req_q)) begin
            // Ack has caught up with req: the destination holds the word.
            irdy_d = 1'b1;
        end
        if (ipush && !irdy_q) begin
            iovf_d = 1'b1;
        end
    end

    always_ff @(posedge inclk) begin
        if (areset) begin
            cap_q      <= kResetTo;
            req_q      <= 1'b0;
            irdy_q     <= 1'b0;
            iovf_q     <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            cap_q      <= cap_d;
            req_q      <= req_d;
            irdy_q     <= irdy_d;
            iovf_q     <= iovf_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign irdy = irdy_q;
    assign iovf = iovf_q;

    // --------------------------------------------------------------- outclk domain
    (* ASYNC_REG = "TRUE" *) logic [kStages-1:0] rst_sync_q;
    (* ASYNC_REG = "TRUE" *) logic [kStages-1:0] req_sync_q;
    logic [kStages-1:0] req_sync_d;
    logic               req_prev_q, req_prev_d;
    logic [kWidth-1:0]  oout_q, oout_d;
    logic               ovalid_q, ovalid_d;
    logic               orst;
    logic               req_s;
    logic               req_edge;

    assign orst     = rst_sync_q[kStages-1];
    assign req_s    = req_sync_q[kStages-1];
    assign req_edge = req_s ^ req_prev_q;

    // Reset synchroniser itself is never reset; it just follows areset.
    always_ff @(posedge outclk) begin
        rst_sync_q <= {rst_sync_q[kStages-2:0], areset};
    end

    always_comb begin
        req_sync_d = {req_sync_q[kStages-2:0], req_q};
        req_prev_d = req_s;
        oout_d     = oout_q;
        ovalid_d   = 1'b0;
        ack_d      = ack_q;
        if (req_edge) begin
            // cap_q has been stable since before req toggled, so sampling it here is safe.
            oout_d   = cap_q;
            ovalid_d = 1'b1;
            ack_d    = req_s;
        end
    end

    always_ff @(posedge outclk) begin
        if (orst) begin
            req_sync_q <= '0;
            req_prev_q <= 1'b0;
            oout_q     <= kResetTo;
            ovalid_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            req_sync_q <= req_sync_d;
            req_prev_q <= req_prev_d;
            oout_q     <= oout_d;
            ovalid_q   <= ovalid_d;
            ack_q      <= ack_d;
        end
    end

    assign oout   = oout_q;
    assign ovalid = ovalid_q;

endmodule

// File: tb/tb_sync_bus_hs.sv
`timescale 1ns/1ps

module tb_sync_bus_hs;

    localparam int unsigned W   = 8;
    localparam int unsigned KS  = 2;
    localparam logic [W-1:0] RST = 8'h00;

    logic         inclk = 1'b0;
    logic         outclk = 1'b0;
    logic         areset = 1'b1;
    logic [W-1:0] iin = '0;
    logic         ipush = 1'b0;
    logic         irdy;
    logic         iovf;
    logic [W-1:0] oout;
    logic         ovalid;

    sync_bus_hs #(
        .kWidth  (W),
        .kStages (KS),
        .kResetTo(RST)
    ) dut (
        .inclk (inclk),
        .areset(areset),
        .outclk(outclk),
        .iin   (iin),
        .ipush (ipush),
        .irdy  (irdy),
        .iovf  (iovf),
        .oout  (oout),
        .ovalid(ovalid)
    );

    // inclk 100 MHz; outclk default 74.25 MHz, period changeable, can be frozen low.
    real out_half = 6.734;
    bit  out_run  = 1'b1;
    always #5 inclk = ~inclk;
    always begin
        #(out_half);
        if (out_run) outclk = ~outclk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int ov_cnt   = 0;
    bit mon_en   = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_out = RST;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every pulse must deliver the next accepted word in order; between
    // pulses oout must keep showing the last delivered word.
    always @(negedge outclk) begin
        logic [W-1:0] w;
        if (ovalid) ov_cnt++;
        if (mon_en) begin
            if (ovalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ovalid_spurious: pulse with oout=%0h, expected no pulse", oout);
                end else begin
                    w = exp_q.pop_front();
                    chk("sb_word", 64'(oout), 64'(w));
                    last_out = w;
                end
            end else begin
                chk("oout_hold", 64'(oout), 64'(last_out));
            end
        end
    end

    // While an accepted word has not yet been delivered the handshake cannot be idle.
    always @(posedge inclk) begin
        #2;
        if (mon_en && exp_q.size() > 0) chk("irdy_busy", 64'(irdy), 64'd0);
    end

    task automatic rst(input int n);
        mon_en = 1'b0;
        @(negedge inclk);
        areset = 1'b1;
        ipush  = 1'b0;
        iin    = RST;
        repeat (n) @(negedge inclk);
        chk("rst_irdy_low", 64'(irdy), 64'd0);
        chk("rst_iovf_low", 64'(iovf), 64'd0);
        exp_q.delete();
        last_out = RST;
        areset = 1'b0;
        @(negedge inclk);
        chk("rst_irdy_rise", 64'(irdy), 64'd1);
        repeat (KS + 3) @(negedge outclk);
        chk("rst_oout", 64'(oout), 64'(RST));
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        mon_en = 1'b1;
    endtask

    task automatic push_rdy(input logic [W-1:0] w);
        int k = 0;
        @(negedge inclk);
        while (!irdy && k < 200) begin
            @(negedge inclk);
            k++;
        end
        if (!irdy) begin
            n_checks++;
            $display("FAIL push_timeout: irdy=0 after %0d cycles, required 1", k);
        end else begin
            iin   = w;
            ipush = 1'b1;
            exp_q.push_back(w);
            @(negedge inclk);
            ipush = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge inclk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        k = 0;
        while (!irdy && k < 200) begin
            @(negedge inclk);
            k++;
        end
        if (!irdy) begin
            n_checks++;
            $display("FAIL irdy_timeout: irdy=0, required 1");
        end
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int ov0;
        int lat;
        int k;
        bit found;

        // ---- reset state
        rst(20);
        chk("init_oout", 64'(oout), 64'h00);

        // ---- basic transfer of 0xA5 with latency bounds
        ov0 = ov_cnt;
        @(negedge inclk);
        chk("a5_irdy_before", 64'(irdy), 64'd1);
        iin   = 8'hA5;
        ipush = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge inclk);
        #1;
        ipush = 1'b0;
        chk("a5_irdy_drop", 64'(irdy), 64'd0);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            @(posedge outclk);
            lat++;
            @(negedge outclk);
            if (ovalid) found = 1'b1;
        end
        chk("a5_latency_in_range", 64'(found && lat >= KS + 1 && lat <= KS + 2), 64'd1);
        chk("a5_oout", 64'(oout), 64'hA5);
        k = 0;
        while (!irdy && k < 20) begin
            @(negedge inclk);
            k++;
        end
        chk("a5_irdy_return_fast", 64'(k <= KS + 2), 64'd1);
        repeat (20) @(negedge inclk);
        chk("a5_one_pulse", 64'(ov_cnt - ov0), 64'd1);
        chk("a5_iovf", 64'(iovf), 64'd0);

        // ---- back-to-back 0x01, 0x02, 0x03
        ov0 = ov_cnt;
        push_rdy(8'h01);
        push_rdy(8'h02);
        push_rdy(8'h03);
        drain();
        repeat (10) @(negedge inclk);
        chk("b2b_pulses", 64'(ov_cnt - ov0), 64'd3);
        chk("b2b_oout", 64'(oout), 64'h03);
        chk("b2b_iovf", 64'(iovf), 64'd0);

        // ---- overflow: 0x22 pushed on the cycle right after 0x11 is dropped
        rst(20);
        ov0 = ov_cnt;
        push_rdy(8'h11);
        chk("ovf_irdy_busy", 64'(irdy), 64'd0);
        iin   = 8'h22;
        ipush = 1'b1;
        @(negedge inclk);
        ipush = 1'b0;
        iin   = 8'h11;
        chk("ovf_set", 64'(iovf), 64'd1);
        drain();
        repeat (20) @(negedge inclk);
        chk("ovf_sticky", 64'(iovf), 64'd1);
        chk("ovf_oout", 64'(oout), 64'h11);
        chk("ovf_one_pulse", 64'(ov_cnt - ov0), 64'd1);
        rst(20);
        chk("ovf_cleared", 64'(iovf), 64'd0);

        // ---- reset mid-flight: 0x5A captured while outclk is held, then reset
        push_rdy(8'h66);
        push_rdy(8'h77);
        drain();
        chk("mf_pre_oout", 64'(oout), 64'h77);
        @(negedge outclk);
        out_run = 1'b0;
        @(negedge inclk);
        chk("mf_irdy", 64'(irdy), 64'd1);
        iin   = 8'h5A;
        ipush = 1'b1;
        @(negedge inclk);
        ipush  = 1'b0;
        iin    = RST;
        areset = 1'b1;
        mon_en = 1'b0;
        ov0    = ov_cnt;
        @(negedge inclk);
        out_run = 1'b1;
        @(negedge inclk);
        @(negedge inclk);
        areset = 1'b0;
        @(negedge inclk);
        chk("mf_irdy_rise", 64'(irdy), 64'd1);
        repeat (KS + 4) @(negedge outclk);
        chk("mf_no_pulse", 64'(ov_cnt - ov0), 64'd0);
        chk("mf_oout_reset", 64'(oout), 64'(RST));
        exp_q.delete();
        last_out = RST;
        mon_en   = 1'b1;
        push_rdy(8'h3C);
        drain();
        chk("mf_oout_3c", 64'(oout), 64'h3C);

        // ---- ratio sweep: outclk 3x then 0.3x inclk, random words at max rate
        out_half = 1.6667;
        rst(20);
        for (int i = 0; i < 1000; i++) push_rdy(W'($urandom));
        drain();
        chk("fast_iovf", 64'(iovf), 64'd0);
        out_half = 16.667;
        rst(20);
        for (int i = 0; i < 1000; i++) push_rdy(W'($urandom));
        drain();
        chk("slow_iovf", 64'(iovf), 64'd0);

        // ---- level following with ipush held low
        out_half = 6.734;
        rst(20);
        ov0 = ov_cnt;
        @(negedge inclk);
        iin = 8'h00;
        repeat (30) @(negedge inclk);
        iin = 8'h7F;
`ifdef SYNC_BUS_CHANGE_PUSH_EN
        exp_q.push_back(8'h7F);
`endif
        repeat (30) @(negedge inclk);
        iin = 8'h7F;
        repeat (30) @(negedge inclk);
        iin = 8'h80;
`ifdef SYNC_BUS_CHANGE_PUSH_EN
        exp_q.push_back(8'h80);
`endif
        repeat (30) @(negedge inclk);
`ifdef SYNC_BUS_CHANGE_PUSH_EN
        chk("lvl_pulses", 64'(ov_cnt - ov0), 64'd2);
        chk("lvl_oout", 64'(oout), 64'h80);
`else
        chk("lvl_pulses", 64'(ov_cnt - ov0), 64'd0);
        chk("lvl_oout", 64'(oout), 64'(RST));
`endif
        chk("lvl_iovf", 64'(iovf), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
